silife_gen_sched: RTL and testbench
===================================

SILIFE_GEN_SCHED -- requirements
Module: silife_gen_sched

Interface
REQ-001 SHALL have parameter PERIOD_WIDTH, default 24: width of the step-period register, in clk cycles.
REQ-002 SHALL have parameter GEN_WIDTH, default 32: width of the generation counter and the generation limit.
REQ-003 SHALL have port clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_run  input  1  level; 1 = free-running generations, 0 = paused.
REQ-006 SHALL have port i_step  input  1  one-cycle pulse requesting a single generation while paused.
REQ-007 SHALL have port i_period  input  PERIOD_WIDTH  cycles between generation steps; sampled at each reload.
REQ-008 SHALL have port i_max_gens  input  GEN_WIDTH  generation limit; 0 = unlimited.
REQ-009 SHALL have port i_busy  input  1  matrix access (Wishbone write or scan) in progress; steps are deferred while high.
REQ-010 SHALL have port i_clear_count  input  1  one-cycle pulse clearing the generation counter and the done state.
REQ-011 SHALL have port o_enable  output  1  one-cycle step pulse driving the matrix enable.
REQ-012 SHALL have port o_gen_count  output  GEN_WIDTH  generations stepped since reset or the last clear.
REQ-013 SHALL have port o_running  output  1  high in states WAIT, HOLD and STEP.
REQ-014 SHALL have port o_done  output  1  high in state DONE.

Function
REQ-015 SHALL implement states IDLE, WAIT, HOLD, STEP and DONE, all registered, with o_enable = (state == STEP).
REQ-016 IDLE: i_run=1 -> WAIT with cnt loaded from i_period; otherwise i_step=1 -> STEP if i_busy=0, else HOLD.
REQ-017 WAIT: i_run=0 -> IDLE with no pulse; cnt<=1 -> STEP if i_busy=0, else HOLD; otherwise cnt decrements.
REQ-018 HOLD: i_busy=0 -> STEP; entered from WAIT with i_run=0 -> IDLE; entered from i_step -> remains in HOLD until i_busy=0, with no timeout.
REQ-019 STEP: for exactly one cycle, increments o_gen_count (wrapping at 2^GEN_WIDTH) and reloads cnt from i_period.
REQ-020 STEP exit, in order: limit reached -> DONE; else i_run=1 -> WAIT; else -> IDLE.
REQ-021 Successive o_enable pulses while running with i_busy=0 SHALL be spaced max(i_period,1)+1 cycles apart; an i_period change takes effect at the next reload only.
REQ-022 i_step SHALL be ignored in WAIT, HOLD, STEP and DONE; a step arriving during busy is never dropped.
REQ-023 DONE: no pulses; i_run=0 -> IDLE; i_clear_count=1 -> IDLE, and the counter is cleared.
REQ-024 i_clear_count SHALL set o_gen_count to 0 in any state; when coincident with STEP, o_gen_count SHALL become 1.
REQ-025 The limit is reached when i_max_gens != 0 and the post-increment count == i_max_gens.

Reset
REQ-026 reset=1 SHALL asynchronously force state IDLE, cnt=0, o_gen_count=0, o_enable=0, o_running=0 and o_done=0.
REQ-027 Reset asserted mid-HOLD or mid-STEP SHALL produce no further pulse; after reset release, operation resumes only on a new i_run or i_step.

Configuration
REQ-028 Macro SILIFE_GEN_LIMIT_EN defined: REQ-023 and REQ-025 SHALL apply.
REQ-029 Macro SILIFE_GEN_LIMIT_EN undefined: i_max_gens SHALL be ignored, DONE SHALL be unreachable and o_done SHALL be tied to 0.

Verification
REQ-030 i_run=1, i_period=4, i_busy=0 -> o_enable pulses every 5 cycles; o_gen_count=3 after the third pulse.
REQ-031 Paused, i_step pulse with i_busy=1 for 6 cycles -> no pulse during busy, one o_enable pulse 1 cycle after busy falls, o_gen_count +1.
REQ-032 i_run=1, i_period=0 -> pulses every 2 cycles; i_run dropped during WAIT -> IDLE, no further pulse.
REQ-033 With SILIFE_GEN_LIMIT_EN defined, i_max_gens=3, i_run=1 -> exactly 3 pulses, then o_done=1 and o_running=0; i_clear_count -> o_gen_count=0, o_done=0.
REQ-034 i_clear_count coincident with STEP at o_gen_count=7 -> o_gen_count=1.
REQ-035 reset asserted during HOLD -> all outputs 0 immediately (before the next clk edge); no pulse after release until i_run or i_step.

Source files
------------

// File: rtl/silife_gen_sched_if.sv
// Control/status bundle between the Life matrix controller and the generation scheduler.
interface silife_gen_sched_if #(
  parameter int unsigned PERIOD_WIDTH = 24,
  parameter int unsigned GEN_WIDTH    = 32
);
  logic                    i_run;
  logic                    i_step;
  logic [PERIOD_WIDTH-1:0] i_period;
  logic [GEN_WIDTH-1:0]    i_max_gens;
  logic                    i_busy;
  logic                    i_clear_count;
  logic                    o_enable;
  logic [GEN_WIDTH-1:0]    o_gen_count;
  logic                    o_running;
  logic                    o_done;

  modport master (
    output i_run, i_step, i_period, i_max_gens, i_busy, i_clear_count,
    input  o_enable, o_gen_count, o_running, o_done
  );

  modport slave (
    input  i_run, i_step, i_period, i_max_gens, i_busy, i_clear_count,
    output o_enable, o_gen_count, o_running, o_done
  );
endinterface

// File: rtl/silife_gen_sched.sv
// Generation scheduler: paces single-cycle matrix enable pulses, free-running or single-step.
// Optional generation limit / DONE state enabled by defining SILIFE_GEN_LIMIT_EN.
module silife_gen_sched #(
  parameter int unsigned PERIOD_WIDTH = 24,
  parameter int unsigned GEN_WIDTH    = 32
) (
  input logic               clk,
  input logic               reset,
  silife_gen_sched_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StWait, StHold, StStep, StDone} state_e;

  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [GEN_WIDTH-1:0]    gen_q, gen_d;
  logic                    from_wait_q, from_wait_d;
  logic [GEN_WIDTH-1:0]    gen_base, gen_inc;
  logic                    limit_hit;

  // A clear coinciding with STEP restarts the count from zero before the increment.
  assign gen_base = bus.i_clear_count ? '0 : gen_q;
  assign gen_inc  = gen_base + GEN_WIDTH'(1);

`ifdef SILIFE_GEN_LIMIT_EN
  assign limit_hit = (bus.i_max_gens != '0) && (gen_inc == bus.i_max_gens);
`else
  logic unused_max_gens;
  assign unused_max_gens = ^bus.i_max_gens;
  assign limit_hit       = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      gen_q       <= '0;
      from_wait_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gen_q       <= gen_d;
      from_wait_q <= from_wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gen_d       = bus.i_clear_count ? '0 : gen_q;
    from_wait_d = from_wait_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_run) begin
          state_d = StWait;
          cnt_d   = bus.i_period;
        end else if (bus.i_step) begin
          from_wait_d = 1'b0;
          state_d     = bus.i_busy ? StHold : StStep;
        end
      end
      StWait: begin
        if (!bus.i_run) begin
          state_d = StIdle;
        end else if (cnt_q <= PERIOD_WIDTH'(1)) begin
          from_wait_d = 1'b1;
          state_d     = bus.i_busy ? StHold : StStep;
        end else begin
          cnt_d = cnt_q - PERIOD_WIDTH'(1);
        end
      end
      StHold: begin
        // Only a free-running hold may be abandoned; a requested single step waits for busy.
        if (from_wait_q && !bus.i_run) begin
          state_d = StIdle;
        end else if (!bus.i_busy) begin
          state_d = StStep;
        end
      end
      StStep: begin
        gen_d = gen_inc;
        cnt_d = bus.i_period;
        if (limit_hit) begin
          state_d = StDone;
        end else if (bus.i_run) begin
          state_d = StWait;
        end else begin
          state_d = StIdle;
        end
      end
      StDone: begin
        if (bus.i_clear_count || !bus.i_run) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.o_enable    = (state_q == StStep);
    bus.o_running   = (state_q == StWait) || (state_q == StHold) || (state_q == StStep);
    bus.o_gen_count = gen_q;
`ifdef SILIFE_GEN_LIMIT_EN
    bus.o_done      = (state_q == StDone);
`else
    bus.o_done      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_silife_gen_sched.sv
// Directed-vector bench for silife_gen_sched; limit scenario runs when SILIFE_GEN_LIMIT_EN is set.
module tb_silife_gen_sched;
  localparam int unsigned PW = 8;
  localparam int unsigned GW = 16;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  silife_gen_sched_if #(.PERIOD_WIDTH(PW), .GEN_WIDTH(GW)) bus ();

  silife_gen_sched #(.PERIOD_WIDTH(PW), .GEN_WIDTH(GW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (bus.o_enable !== 1'b0) begin
      n_err++; $display("FAIL reset_enable: got %b expected 0", bus.o_enable);
    end
    n_vec++;
    if (bus.o_gen_count !== '0) begin
      n_err++; $display("FAIL reset_count: got %0d expected 0", bus.o_gen_count);
    end
    n_vec++;
    if (bus.o_running !== 1'b0) begin
      n_err++; $display("FAIL reset_running: got %b expected 0", bus.o_running);
    end
    n_vec++;
    if (bus.o_done !== 1'b0) begin
      n_err++; $display("FAIL reset_done: got %b expected 0", bus.o_done);
    end
    n_vec++;
  endtask

  // Period 4: first pulse 5 cycles after run rises, then every 5 cycles.
  task automatic test_free_run();
    bus.i_period = PW'(4);
    bus.i_run    = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (bus.o_enable !== ((t % 5) == 0)) begin
        n_err++; $display("FAIL free_run_enable t=%0d: got %b expected %b", t, bus.o_enable,
                          (t % 5) == 0);
      end
      n_vec++;
    end
    bus.i_run = 1'b0;
    tick();
    if (bus.o_gen_count !== GW'(3)) begin
      n_err++; $display("FAIL free_run_count: got %0d expected 3", bus.o_gen_count);
    end
    n_vec++;
    if (bus.o_running !== 1'b0) begin
      n_err++; $display("FAIL free_run_stop: got %b expected 0", bus.o_running);
    end
    n_vec++;
  endtask

  task automatic test_step_busy();
    bus.i_busy = 1'b1;
    bus.i_step = 1'b1;
    tick();
    bus.i_step = 1'b0;
    if (bus.o_running !== 1'b1) begin
      n_err++; $display("FAIL step_hold_running: got %b expected 1", bus.o_running);
    end
    n_vec++;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (bus.o_enable !== 1'b0) begin
        n_err++; $display("FAIL step_busy_enable t=%0d: got %b expected 0", t, bus.o_enable);
      end
      n_vec++;
    end
    bus.i_busy = 1'b0;
    tick();
    if (bus.o_enable !== 1'b1) begin
      n_err++; $display("FAIL step_after_busy: got %b expected 1", bus.o_enable);
    end
    n_vec++;
    tick();
    if (bus.o_gen_count !== GW'(4)) begin
      n_err++; $display("FAIL step_busy_count: got %0d expected 4", bus.o_gen_count);
    end
    n_vec++;
    // Unblocked step pulses on the very next cycle.
    bus.i_step = 1'b1;
    tick();
    bus.i_step = 1'b0;
    if (bus.o_enable !== 1'b1) begin
      n_err++; $display("FAIL step_free: got %b expected 1", bus.o_enable);
    end
    n_vec++;
    tick();
    if (bus.o_running !== 1'b0 || bus.o_gen_count !== GW'(5)) begin
      n_err++; $display("FAIL step_free_after: got run=%b cnt=%0d expected run=0 cnt=5",
                        bus.o_running, bus.o_gen_count);
    end
    n_vec++;
  endtask

  task automatic test_period_zero();
    bus.i_period = '0;
    bus.i_run    = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (bus.o_enable !== ((t % 2) == 0)) begin
        n_err++; $display("FAIL period0_enable t=%0d: got %b expected %b", t, bus.o_enable,
                          (t % 2) == 0);
      end
      n_vec++;
    end
    // Now in WAIT; dropping run must return to IDLE with no pulse.
    bus.i_run = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (bus.o_enable !== 1'b0 || bus.o_running !== 1'b0) begin
        n_err++; $display("FAIL period0_stop t=%0d: got en=%b run=%b expected 0 0", t,
                          bus.o_enable, bus.o_running);
      end
      n_vec++;
    end
    if (bus.o_gen_count !== GW'(8)) begin
      n_err++; $display("FAIL period0_count: got %0d expected 8", bus.o_gen_count);
    end
    n_vec++;
  endtask

  // A period change during WAIT only applies at the next reload.
  task automatic test_period_change();
    bit exp;
    bus.i_period = PW'(3);
    bus.i_run    = 1'b1;
    tick();
    bus.i_period = PW'(1);
    for (int t = 2; t <= 6; t++) begin
      tick();
      exp = (t == 4) || (t == 6);
      if (bus.o_enable !== exp) begin
        n_err++; $display("FAIL period_change t=%0d: got %b expected %b", t, bus.o_enable, exp);
      end
      n_vec++;
    end
    bus.i_run = 1'b0;
    tick();
    if (bus.o_gen_count !== GW'(10)) begin
      n_err++; $display("FAIL period_change_count: got %0d expected 10", bus.o_gen_count);
    end
    n_vec++;
  endtask

  task automatic test_wait_busy_abort();
    bus.i_period = PW'(1);
    bus.i_busy   = 1'b1;
    bus.i_run    = 1'b1;
    tick();
    tick();
    if (bus.o_running !== 1'b1 || bus.o_enable !== 1'b0) begin
      n_err++; $display("FAIL wait_hold: got run=%b en=%b expected 1 0", bus.o_running,
                        bus.o_enable);
    end
    n_vec++;
    bus.i_run = 1'b0;
    tick();
    bus.i_busy = 1'b0;
    tick();
    if (bus.o_running !== 1'b0 || bus.o_enable !== 1'b0 || bus.o_gen_count !== GW'(10)) begin
      n_err++; $display("FAIL wait_abort: got run=%b en=%b cnt=%0d expected 0 0 10",
                        bus.o_running, bus.o_enable, bus.o_gen_count);
    end
    n_vec++;
  endtask

  task automatic test_clear_step();
    int pulses;
    bus.i_clear_count = 1'b1;
    tick();
    bus.i_clear_count = 1'b0;
    if (bus.o_gen_count !== '0) begin
      n_err++; $display("FAIL clear_idle: got %0d expected 0", bus.o_gen_count);
    end
    n_vec++;
    pulses = 0;
    bus.i_period = '0;
    bus.i_run    = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (bus.o_enable === 1'b1) pulses++;
    end
    if (pulses != 8 || bus.o_enable !== 1'b1 || bus.o_gen_count !== GW'(7)) begin
      n_err++; $display("FAIL clear_step_setup: got pulses=%0d en=%b cnt=%0d expected 8 1 7",
                        pulses, bus.o_enable, bus.o_gen_count);
    end
    n_vec++;
    bus.i_clear_count = 1'b1;
    bus.i_run         = 1'b0;
    tick();
    bus.i_clear_count = 1'b0;
    if (bus.o_gen_count !== GW'(1)) begin
      n_err++; $display("FAIL clear_with_step: got %0d expected 1", bus.o_gen_count);
    end
    n_vec++;
  endtask

  task automatic test_reset_hold();
    bus.i_busy = 1'b1;
    bus.i_step = 1'b1;
    tick();
    bus.i_step = 1'b0;
    reset = 1'b1;
    #1;
    if (bus.o_running !== 1'b0 || bus.o_enable !== 1'b0 || bus.o_gen_count !== '0) begin
      n_err++; $display("FAIL reset_async: got run=%b en=%b cnt=%0d expected 0 0 0",
                        bus.o_running, bus.o_enable, bus.o_gen_count);
    end
    n_vec++;
    tick();
    reset      = 1'b0;
    bus.i_busy = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (bus.o_enable !== 1'b0 || bus.o_running !== 1'b0) begin
        n_err++; $display("FAIL reset_no_resume t=%0d: got en=%b run=%b expected 0 0", t,
                          bus.o_enable, bus.o_running);
      end
      n_vec++;
    end
    bus.i_step = 1'b1;
    tick();
    bus.i_step = 1'b0;
    if (bus.o_enable !== 1'b1) begin
      n_err++; $display("FAIL reset_resume_step: got %b expected 1", bus.o_enable);
    end
    n_vec++;
    tick();
  endtask

`ifdef SILIFE_GEN_LIMIT_EN
  task automatic test_limit();
    int pulses;
    bus.i_clear_count = 1'b1;
    tick();
    bus.i_clear_count = 1'b0;
    pulses          = 0;
    bus.i_max_gens  = GW'(3);
    bus.i_period    = PW'(1);
    bus.i_run       = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (bus.o_enable === 1'b1) pulses++;
    end
    if (pulses != 3 || bus.o_done !== 1'b1 || bus.o_running !== 1'b0 ||
        bus.o_gen_count !== GW'(3)) begin
      n_err++; $display("FAIL limit: got pulses=%0d done=%b run=%b cnt=%0d expected 3 1 0 3",
                        pulses, bus.o_done, bus.o_running, bus.o_gen_count);
    end
    n_vec++;
    bus.i_clear_count = 1'b1;
    bus.i_run         = 1'b0;
    tick();
    bus.i_clear_count = 1'b0;
    if (bus.o_done !== 1'b0 || bus.o_gen_count !== '0) begin
      n_err++; $display("FAIL limit_clear: got done=%b cnt=%0d expected 0 0", bus.o_done,
                        bus.o_gen_count);
    end
    n_vec++;
    bus.i_max_gens = '0;
  endtask
`endif

  initial begin
    n_vec             = 0;
    n_err             = 0;
    reset             = 1'b1;
    bus.i_run         = 1'b0;
    bus.i_step        = 1'b0;
    bus.i_period      = '0;
    bus.i_max_gens    = '0;
    bus.i_busy        = 1'b0;
    bus.i_clear_count = 1'b0;
    #2;
    test_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_free_run();
    test_step_busy();
    test_period_zero();
    test_period_change();
    test_wait_busy_abort();
    test_clear_step();
    test_reset_hold();
`ifdef SILIFE_GEN_LIMIT_EN
    test_limit();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
